// File: rtl/cacheline_burst_adaptor.sv
// Memory-side adaptor: turns one cache line fill/writeback into a burst of beats
// and returns a single-cycle completion pulse with the assembled line.
module cacheline_burst_adaptor #(
    parameter int LINE_W   = 256,
    parameter int BURST_W  = 64,
    parameter int OFFSET_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [31:0]        line_addr_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               line_resp_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_address_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               mem_resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    count_r;
    logic [LINE_W-1:0]   buf_r;
    logic [31:0]         addr_r;
    logic [BURST_W-1:0]  burst_r;
    logic                mem_read_r;
    logic                mem_write_r;
    logic                resp_r;

    logic [31:0]         aligned_addr_s;
    logic [CNT_W-1:0]    next_cnt_s;
    logic                unused_offset_s;

    // Select beat idx of a line (beat 0 = least significant bits).
    function automatic logic [BURST_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                   input logic [CNT_W-1:0]  idx);
        logic [BURST_W-1:0] res;
        res = {BURST_W{1'b0}};
        for (int b = 0; b < BEATS; b++) begin
            if (idx == CNT_W'(b)) begin
                res = line[b*BURST_W +: BURST_W];
            end
        end
        return res;
    endfunction

    // Return line with beat idx replaced by beat.
    function automatic logic [LINE_W-1:0] insert_beat(input logic [LINE_W-1:0]  line,
                                                      input logic [CNT_W-1:0]   idx,
                                                      input logic [BURST_W-1:0] beat);
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < BEATS; b++) begin
            if (idx == CNT_W'(b)) begin
                res[b*BURST_W +: BURST_W] = beat;
            end
        end
        return res;
    endfunction

    assign aligned_addr_s  = {line_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign next_cnt_s      = count_r + CNT_W'(1);
    assign unused_offset_s = ^line_addr_i[OFFSET_W-1:0];

    // Burst sequencer: accepts a request in IDLE, walks the beats, then pulses resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNT_W{1'b0}};
            buf_r       <= {LINE_W{1'b0}};
            addr_r      <= 32'h0000_0000;
            burst_r     <= {BURST_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            resp_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_r <= 1'b0;
                    // Writeback wins; a concurrent fill stays pending at the cache.
                    if (line_write_i) begin
                        state_r     <= ST_WRITE;
                        mem_write_r <= 1'b1;
                        addr_r      <= aligned_addr_s;
                        buf_r       <= line_i;
                        burst_r     <= line_i[BURST_W-1:0];
                        count_r     <= {CNT_W{1'b0}};
                    end else if (line_read_i) begin
                        state_r    <= ST_READ;
                        mem_read_r <= 1'b1;
                        addr_r     <= aligned_addr_s;
                        count_r    <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_resp_i) begin
                        count_r <= next_cnt_s;
                        if (count_r == LAST_BEAT) begin
                            state_r     <= ST_DONE;
                            mem_write_r <= 1'b0;
                            resp_r      <= 1'b1;
                            burst_r     <= {BURST_W{1'b0}};
                        end else begin
                            burst_r <= beat_of(buf_r, next_cnt_s);
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_READ: begin
                    if (mem_resp_i) begin
                        buf_r   <= insert_beat(buf_r, count_r, burst_i);
                        count_r <= next_cnt_s;
                        if (count_r == LAST_BEAT) begin
                            state_r    <= ST_DONE;
                            mem_read_r <= 1'b0;
                            resp_r     <= 1'b1;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_DONE: begin
                    resp_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= {CNT_W{1'b0}};
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    resp_r      <= 1'b0;
                end
            endcase
        end
    end

    assign line_o        = buf_r;
    assign line_resp_o   = resp_r;
    assign mem_read_o    = mem_read_r;
    assign mem_write_o   = mem_write_r;
    assign mem_address_o = addr_r;
    assign burst_o       = burst_r;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Self-checking bench for cacheline_burst_adaptor: directed vector table, corner
// sequences and randomized transactions against a transaction-level model.
module tb_cacheline_burst_adaptor;

    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         line_read_i, line_write_i, mem_resp_i;
    logic [31:0]  line_addr_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         line_resp_o, mem_read_o, mem_write_o;
    logic [31:0]  mem_address_o;
    logic [63:0]  burst_o, burst_i;

    int checks = 0;
    int errors = 0;
    int resp_seen = 0;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst_n(rst_n),
        .line_read_i(line_read_i), .line_write_i(line_write_i),
        .line_addr_i(line_addr_i), .line_i(line_i), .line_o(line_o),
        .line_resp_o(line_resp_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .burst_o(burst_o), .burst_i(burst_i),
        .mem_resp_i(mem_resp_i)
    );

    always #5 clk = ~clk;

    // Count completion pulses mid-cycle.
    always @(negedge clk) if (rst_n && line_resp_o) resp_seen++;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic [255:0] l, input int i);
        return 64'(l >> (64 * i));
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One full transaction. mode 0: back-to-back resp, 1: random gaps, 2: pattern 1,0,0,1,1,0,1
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                           input logic [31:0] exp_addr, input logic [255:0] exp_line,
                           input int mode, input bit toggle_other, input string tag);
        int b;
        int cyc;
        int r0;
        bit give;
        logic [6:0] pat;
        pat = 7'h59;
        b = 0;
        cyc = 0;
        r0 = resp_seen;
        line_addr_i = addr;
        if (wr) begin
            line_write_i = 1'b1;
            line_i = data;
        end else begin
            line_read_i = 1'b1;
        end
        tick;
        line_i = ~data;
        line_addr_i = $urandom;
        chk({tag, " addr"}, 256'(mem_address_o), 256'(exp_addr));
        chk({tag, " req"}, 256'({mem_write_o, mem_read_o}), 256'({wr, !wr}));
        while (b < BEATS && cyc < 200) begin
            case (mode)
                0: give = 1'b1;
                1: give = ($urandom_range(0, 99) >= 30);
                2: give = (cyc < 7) ? pat[cyc] : 1'b1;
                default: give = 1'b1;
            endcase
            if (toggle_other) line_write_i = 1'($urandom_range(0, 1));
            chk({tag, " no early resp"}, 256'(line_resp_o), 256'(0));
            chk({tag, " req held"}, 256'({mem_write_o, mem_read_o}), 256'({wr, !wr}));
            if (wr) chk({tag, " burst_o"}, 256'(burst_o), 256'(beat(exp_line, b)));
            mem_resp_i = give;
            burst_i = give ? beat(data, b) : {$urandom, $urandom};
            tick;
            cyc++;
            if (give) b++;
        end
        if (b < BEATS) begin
            errors++;
            $display("FAIL %s timeout: beats %0d required %0d", tag, b, BEATS);
        end
        mem_resp_i = 1'b0;
        if (toggle_other) line_write_i = 1'b0;
        chk({tag, " resp"}, 256'(line_resp_o), 256'(1));
        chk({tag, " req drop"}, 256'({mem_write_o, mem_read_o}), 256'(0));
        chk({tag, " line_o"}, line_o, exp_line);
        chk({tag, " addr hold"}, 256'(mem_address_o), 256'(exp_addr));
        if (mode == 2) chk({tag, " cycles"}, 256'(cyc), 256'(7));
        if (wr) line_write_i = 1'b0;
        else line_read_i = 1'b0;
        tick;
        chk({tag, " resp one cycle"}, 256'(line_resp_o), 256'(0));
        chk({tag, " resp count"}, 256'(resp_seen - r0), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] l1, inc, held;
        logic [31:0]  a;
        bit           w;
        int           r0;
        l1  = {64'h4444444444444444, 64'h3333333333333333,
               64'h2222222222222222, 64'h1111111111111111};
        inc = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
        vecs[0] = '{1'b0, 32'h0000_1234, l1,  32'h0000_1220, l1};
        vecs[1] = '{1'b1, 32'h8000_0040, inc, 32'h8000_0040, inc};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, ~l1, 32'hFFFF_FFE0, ~l1};
        vecs[3] = '{1'b1, 32'h0000_001F, ~inc, 32'h0000_0000, ~inc};
        vecs[4] = '{1'b0, 32'h0000_0000, inc, 32'h0000_0000, inc};
        vecs[5] = '{1'b1, 32'hDEAD_BEEF, l1,  32'hDEAD_BEE0, l1};

        rst_n = 1'b0;
        line_read_i = 1'b0; line_write_i = 1'b0; mem_resp_i = 1'b0;
        line_addr_i = 32'h0; line_i = 256'h0; burst_i = 64'h0;
        #12;
        chk("reset outputs", {line_o}, 256'h0);
        chk("reset ctrl", 256'({line_resp_o, mem_read_o, mem_write_o, mem_address_o, burst_o}), 256'h0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        chk("post-reset idle", 256'({line_resp_o, mem_read_o, mem_write_o, mem_address_o}), 256'h0);

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_addr,
                    vecs[i].exp_line, 0, 1'b0, $sformatf("vec%0d", i));

        run_txn(1'b0, 32'h0000_4444, l1, 32'h0000_4440, l1, 2, 1'b0, "gap pattern");

        // Simultaneous read and write: writeback first, read follows.
        r0 = resp_seen;
        line_read_i = 1'b1;
        run_txn(1'b1, 32'h0000_2000, inc, 32'h0000_2000, inc, 0, 1'b0, "prio write");
        chk("prio idle gap", 256'({mem_write_o, mem_read_o}), 256'(0));
        run_txn(1'b0, 32'h0000_3000, l1, 32'h0000_3000, l1, 0, 1'b0, "prio read");
        chk("prio two resps", 256'(resp_seen - r0), 256'(2));

        // Reset in the middle of a fill.
        r0 = resp_seen;
        line_addr_i = 32'h0000_5555;
        line_read_i = 1'b1;
        tick;
        mem_resp_i = 1'b1;
        burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        tick;
        tick;
        mem_resp_i = 1'b0;
        line_read_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset line", line_o, 256'h0);
        chk("async reset ctrl", 256'({line_resp_o, mem_read_o, mem_write_o, mem_address_o, burst_o}), 256'h0);
        tick;
        tick;
        @(negedge clk) rst_n = 1'b1;
        tick;
        chk("no resp after reset", 256'(resp_seen - r0), 256'(0));
        run_txn(1'b0, 32'h0000_6666, inc, 32'h0000_6660, inc, 0, 1'b0, "post reset read");

        // Stray memory responses while idle.
        held = line_o;
        for (int i = 0; i < 4; i++) begin
            mem_resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            tick;
            chk("idle stray resp", 256'({line_resp_o, mem_read_o, mem_write_o}), 256'(0));
            chk("idle line hold", line_o, held);
        end
        mem_resp_i = 1'b0;
        run_txn(1'b0, 32'h0000_7777, l1, 32'h0000_7760, l1, 1, 1'b1, "write toggle");

        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            l1 = rand_line();
            run_txn(w, a, l1, a & 32'hFFFF_FFE0, l1, 1, 1'b0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
